// File: rtl/fp_bist_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fp_bist_pkg                                                   |
// | Description : Shared constants for the floating-point add/sub self-test   |
// |               sequencer: FSM state encoding, test-vector field offsets    |
// |               and the adder opcode constants.                              |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package fp_bist_pkg;

  // FSM state encoding (3-bit, IDLE=0 .. DONE=5).
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Vector layout {a, b, expected}; each field is 32 bits wide below its MSB.
  localparam int A_MSB   = 95;
  localparam int B_MSB   = 63;
  localparam int EXP_MSB = 31;

  // Opcode shared with the adder wrapper.
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage : fp_bist_pkg
`default_nettype wire

// File: rtl/fp_bist_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_bist_sat_counter                                           |
// | Description : Saturating up-counter used for the pass/fail tallies.        |
// |               Synchronous clear has priority over increment; the count     |
// |               sticks at all-ones instead of wrapping.                      |
// | Revision    : 1.0  initial release                                          |
// | Ports       : clk, rst_n (sync, active low), clr, inc, count[CNT_W-1:0]    |
// +----------------------------------------------------------------------------+
module fp_bist_sat_counter #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : fp_bist_sat_counter
`default_nettype wire

// File: rtl/fp_addsub_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_addsub_bist                                                |
// | Description : Self-test sequencer for the combinational FP add/sub unit.   |
// |               Reads {a, b, expected} vectors from a synchronous ROM,       |
// |               drives the adder, waits SETTLE cycles, compares              |
// |               result[31:CMP_LSB] and tallies pass/fail counts.             |
// | Revision    : 1.0  initial release                                          |
// | Ports       : clk, rst_n (sync, active low), start (pulse)                 |
// |               vec_addr/vec_rd -> ROM, vec_data <- ROM (1-cycle latency)    |
// |               a_operand/b_operand/AddBar_Sub -> adder, result <- adder     |
// |               busy, done (sticky), pass_count, fail_count                  |
// | Options     : `define FP_BIST_FAIL_LOG_EN adds first_fail_valid/idx/exp/got|
// |               which capture the first failing vector of each run.          |
// +----------------------------------------------------------------------------+
module fp_addsub_bist
  import fp_bist_pkg::*;
#(
  parameter int N_TESTS = 100000,
  parameter int ADDR_W  = 17,
  parameter int CNT_W   = 17,
  parameter int SETTLE  = 1,
  parameter int CMP_LSB = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              vec_rd,
  input  logic [95:0]       vec_data,
  output logic [31:0]       a_operand,
  output logic [31:0]       b_operand,
  output logic              AddBar_Sub,
  input  logic [31:0]       result,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count
`ifdef FP_BIST_FAIL_LOG_EN
  ,
  output logic              first_fail_valid,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic [31:0]       first_fail_exp,
  output logic [31:0]       first_fail_got
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(N_TESTS - 1);
  localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE - 1);
  // Ones on the compared bits only; the low mantissa bits are don't-care.
  localparam logic [31:0]       CMP_MASK    = ~((32'd1 << CMP_LSB) - 32'd1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       a_operand_q, a_operand_d;
  logic [31:0]       b_operand_q, b_operand_d;
  logic [31:0]       exp_q, exp_d;
  logic [3:0]        settle_q, settle_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              cnt_clr;
  logic              pass_inc;
  logic              fail_inc;
  logic              match;

`ifdef FP_BIST_FAIL_LOG_EN
  logic              ff_valid_q, ff_valid_d;
  logic [ADDR_W-1:0] ff_idx_q, ff_idx_d;
  logic [31:0]       ff_exp_q, ff_exp_d;
  logic [31:0]       ff_got_q, ff_got_d;
`endif

  // XOR-and-mask keeps every result bit in the expression while only the
  // upper bits decide the outcome.
  assign match = (((result ^ exp_q) & CMP_MASK) == 32'd0);

  // State register (all sequencer flops).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_operand_q <= '0;
      b_operand_q <= '0;
      exp_q       <= '0;
      settle_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef FP_BIST_FAIL_LOG_EN
      ff_valid_q  <= 1'b0;
      ff_idx_q    <= '0;
      ff_exp_q    <= '0;
      ff_got_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_operand_q <= a_operand_d;
      b_operand_q <= b_operand_d;
      exp_q       <= exp_d;
      settle_q    <= settle_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef FP_BIST_FAIL_LOG_EN
      ff_valid_q  <= ff_valid_d;
      ff_idx_q    <= ff_idx_d;
      ff_exp_q    <= ff_exp_d;
      ff_got_q    <= ff_got_d;
`endif
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_operand_d = a_operand_q;
    b_operand_d = b_operand_q;
    exp_d       = exp_q;
    settle_d    = settle_q;
    busy_d      = busy_q;
    done_d      = done_q;
    cnt_clr     = 1'b0;
    pass_inc    = 1'b0;
    fail_inc    = 1'b0;
`ifdef FP_BIST_FAIL_LOG_EN
    ff_valid_d  = ff_valid_q;
    ff_idx_d    = ff_idx_q;
    ff_exp_d    = ff_exp_q;
    ff_got_d    = ff_got_q;
`endif
    case (state_q)
      // start is only looked at here, which is why it is ignored while busy.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cnt_clr = 1'b1;
          idx_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
`ifdef FP_BIST_FAIL_LOG_EN
          ff_valid_d = 1'b0;
          ff_idx_d   = '0;
          ff_exp_d   = '0;
          ff_got_d   = '0;
`endif
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        a_operand_d = vec_data[A_MSB -: 32];
        b_operand_d = vec_data[B_MSB -: 32];
        exp_d       = vec_data[EXP_MSB -: 32];
        settle_d    = SETTLE_LOAD;
        state_d     = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ST_CHECK: begin
        pass_inc = match;
        fail_inc = ~match;
`ifdef FP_BIST_FAIL_LOG_EN
        if (!match && !ff_valid_q) begin
          ff_valid_d = 1'b1;
          ff_idx_d   = idx_q;
          ff_exp_d   = exp_q;
          ff_got_d   = result;
        end
`endif
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state. idx only moves on entry to FETCH, so
  // vec_addr naturally holds between reads.
  always_comb begin
    vec_rd     = (state_q == ST_FETCH);
    vec_addr   = idx_q;
    AddBar_Sub = ADD;
  end

  fp_bist_sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (pass_inc),
    .count (pass_count)
  );

  fp_bist_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (fail_inc),
    .count (fail_count)
  );

  assign a_operand = a_operand_q;
  assign b_operand = b_operand_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef FP_BIST_FAIL_LOG_EN
  assign first_fail_valid = ff_valid_q;
  assign first_fail_idx   = ff_idx_q;
  assign first_fail_exp   = ff_exp_q;
  assign first_fail_got   = ff_got_q;
`endif

endmodule : fp_addsub_bist
`default_nettype wire

// File: tb/tb_fp_addsub_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fp_addsub_bist                                             |
// | Description : Scoreboard bench for fp_addsub_bist. Two instances:         |
// |               A: 3 vectors, SETTLE=4, 17-bit counters                      |
// |               B: 3 vectors, SETTLE=1, 1-bit counters (saturation)          |
// |               Each run pushes its hand-computed outcome; a monitor per     |
// |               instance pops and compares on the rising edge of done.       |
// |               Honours FP_BIST_FAIL_LOG_EN for the first-fail outputs.      |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_fp_addsub_bist;

  typedef struct {
    string       name;
    int          cyc0;
    int          cycles;
    logic [63:0] pass;
    logic [63:0] fail;
    logic [63:0] ffv;
    logic [63:0] ffidx;
    logic [63:0] ffexp;
    logic [63:0] ffgot;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Known-good sums of the operand pairs used below; anything else is a NaN.
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      64'h3F800000_3F800000: return 32'h40000000;  // 1 + 1 = 2
      64'h40000000_3F800000: return 32'h40400000;  // 2 + 1 = 3
      64'h3F800000_BF800000: return 32'h00000000;  // 1 + -1 = 0
      64'h40400000_3F800000: return 32'h40800000;  // 3 + 1 = 4
      default:               return 32'h7FC00000;
    endcase
  endfunction

  // ---------------- instance A ----------------
  logic [1:0]  a_vec_addr;
  logic        a_vec_rd;
  logic [95:0] a_vec_data;
  logic [31:0] a_a, a_b, a_res;
  logic        a_addsub, a_busy, a_done;
  logic [16:0] a_pass, a_fail;
  logic [95:0] rom_a [4];
`ifdef FP_BIST_FAIL_LOG_EN
  logic        a_ffv;
  logic [1:0]  a_ffidx;
  logic [31:0] a_ffexp, a_ffgot;
`endif

  always @(posedge clk) if (a_vec_rd) a_vec_data <= rom_a[a_vec_addr];
  assign a_res = fadd(a_a, a_b);

  fp_addsub_bist #(.N_TESTS(3), .ADDR_W(2), .CNT_W(17), .SETTLE(4), .CMP_LSB(11)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .vec_addr(a_vec_addr), .vec_rd(a_vec_rd), .vec_data(a_vec_data),
    .a_operand(a_a), .b_operand(a_b), .AddBar_Sub(a_addsub), .result(a_res),
    .busy(a_busy), .done(a_done), .pass_count(a_pass), .fail_count(a_fail)
`ifdef FP_BIST_FAIL_LOG_EN
    , .first_fail_valid(a_ffv), .first_fail_idx(a_ffidx),
    .first_fail_exp(a_ffexp), .first_fail_got(a_ffgot)
`endif
  );

  // ---------------- instance B ----------------
  logic [1:0]  b_vec_addr;
  logic        b_vec_rd;
  logic [95:0] b_vec_data;
  logic [31:0] b_a, b_b, b_res;
  logic        b_addsub, b_busy, b_done;
  logic [0:0]  b_pass, b_fail;
  logic [95:0] rom_b [4];
`ifdef FP_BIST_FAIL_LOG_EN
  logic        b_ffv;
  logic [1:0]  b_ffidx;
  logic [31:0] b_ffexp, b_ffgot;
`endif

  always @(posedge clk) if (b_vec_rd) b_vec_data <= rom_b[b_vec_addr];
  assign b_res = fadd(b_a, b_b);

  fp_addsub_bist #(.N_TESTS(3), .ADDR_W(2), .CNT_W(1), .SETTLE(1), .CMP_LSB(11)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .vec_addr(b_vec_addr), .vec_rd(b_vec_rd), .vec_data(b_vec_data),
    .a_operand(b_a), .b_operand(b_b), .AddBar_Sub(b_addsub), .result(b_res),
    .busy(b_busy), .done(b_done), .pass_count(b_pass), .fail_count(b_fail)
`ifdef FP_BIST_FAIL_LOG_EN
    , .first_fail_valid(b_ffv), .first_fail_idx(b_ffidx),
    .first_fail_exp(b_ffexp), .first_fail_got(b_ffgot)
`endif
  );

  // ---------------- checking helpers ----------------
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", n, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input string n, input int cycles, input int p, input int f,
                              input int ffv, input int ffidx,
                              input logic [31:0] ffexp, input logic [31:0] ffgot);
    exp_t e;
    e.name = n;   e.cyc0 = 0;     e.cycles = cycles;
    e.pass = 64'(p); e.fail = 64'(f);
    e.ffv = 64'(ffv); e.ffidx = 64'(ffidx);
    e.ffexp = 64'(ffexp); e.ffgot = 64'(ffgot);
    return e;
  endfunction

  // ---------------- monitors ----------------
  logic a_done_prev = 1'b0;
  logic b_done_prev = 1'b0;
  exp_t ea, eb;

  always @(negedge clk) begin
    if (a_done && !a_done_prev) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_done got=1 want=0");
      end else begin
        ea = qa.pop_front();
        chk({ea.name, "_cycles"}, 64'(cyc - ea.cyc0), 64'(ea.cycles));
        chk({ea.name, "_pass"}, 64'(a_pass), ea.pass);
        chk({ea.name, "_fail"}, 64'(a_fail), ea.fail);
        chk({ea.name, "_busy"}, 64'(a_busy), 64'd0);
`ifdef FP_BIST_FAIL_LOG_EN
        chk({ea.name, "_ffv"}, 64'(a_ffv), ea.ffv);
        chk({ea.name, "_ffidx"}, 64'(a_ffidx), ea.ffidx);
        chk({ea.name, "_ffexp"}, 64'(a_ffexp), ea.ffexp);
        chk({ea.name, "_ffgot"}, 64'(a_ffgot), ea.ffgot);
`endif
      end
    end
    a_done_prev = a_done;
  end

  always @(negedge clk) begin
    if (b_done && !b_done_prev) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_done got=1 want=0");
      end else begin
        eb = qb.pop_front();
        chk({eb.name, "_cycles"}, 64'(cyc - eb.cyc0), 64'(eb.cycles));
        chk({eb.name, "_pass"}, 64'(b_pass), eb.pass);
        chk({eb.name, "_fail"}, 64'(b_fail), eb.fail);
`ifdef FP_BIST_FAIL_LOG_EN
        chk({eb.name, "_ffv"}, 64'(b_ffv), eb.ffv);
        chk({eb.name, "_ffidx"}, 64'(b_ffidx), eb.ffidx);
        chk({eb.name, "_ffexp"}, 64'(b_ffexp), eb.ffexp);
        chk({eb.name, "_ffgot"}, 64'(b_ffgot), eb.ffgot);
`endif
      end
    end
    b_done_prev = b_done;
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input string n, input bit is_b);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (is_b ? b_done : a_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout got=no_done want=done", n);
    end
    @(negedge clk);
  endtask

  // Issues start, records the expected outcome, checks the immediate
  // effects of start (done drops, busy rises, counters cleared).
  task automatic run(input exp_t e, input bit is_b, input bit mid_start);
    @(negedge clk);
    if (is_b) start_b = 1'b1; else start_a = 1'b1;
    e.cyc0 = cyc + 1;
    if (is_b) qb.push_back(e); else qa.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk({e.name, "_done_drop"}, 64'(is_b ? b_done : a_done), 64'd0);
    chk({e.name, "_busy_rise"}, 64'(is_b ? b_busy : a_busy), 64'd1);
    chk({e.name, "_pass_clr"}, is_b ? 64'(b_pass) : 64'(a_pass), 64'd0);
    chk({e.name, "_fail_clr"}, is_b ? 64'(b_fail) : 64'(a_fail), 64'd0);
    if (mid_start) begin
      repeat (5) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    wait_done(e.name, is_b);
  endtask

  initial begin
    // pass (2==2), fail (2 vs 3), pass (3 vs 3 + 1 LSB, below the compare)
    rom_a[0] = {32'h3F800000, 32'h3F800000, 32'h40000000};
    rom_a[1] = {32'h3F800000, 32'h3F800000, 32'h40400000};
    rom_a[2] = {32'h40000000, 32'h3F800000, 32'h40400001};
    rom_a[3] = '0;
    rom_b[0] = {32'h3F800000, 32'h3F800000, 32'h40000000};
    rom_b[1] = {32'h40000000, 32'h3F800000, 32'h40400000};
    rom_b[2] = {32'h3F800000, 32'hBF800000, 32'h00000800};
    rom_b[3] = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_a_busy", 64'(a_busy), 64'd0);
    chk("rst_a_done", 64'(a_done), 64'd0);
    chk("rst_a_pass", 64'(a_pass), 64'd0);
    chk("rst_a_fail", 64'(a_fail), 64'd0);
    chk("rst_a_opa", 64'(a_a), 64'd0);
    chk("rst_a_opb", 64'(a_b), 64'd0);
    chk("rst_a_rd", 64'(a_vec_rd), 64'd0);
    chk("rst_a_addr", 64'(a_vec_addr), 64'd0);
    chk("rst_a_addsub", 64'(a_addsub), 64'd0);
    chk("rst_b_done", 64'(b_done), 64'd0);
`ifdef FP_BIST_FAIL_LOG_EN
    chk("rst_a_ffv", 64'(a_ffv), 64'd0);
`endif

    // 3 vectors x (4+3) cycles; a start pulse mid-run must not restart it.
    run(mk("a_run1", 21, 2, 1, 1, 1, 32'h40400000, 32'h40000000), 1'b0, 1'b1);
    chk("a_done_sticky", 64'(a_done), 64'd1);
    chk("a_ops_hold", {a_a, a_b}, {32'h40000000, 32'h3F800000});
    // Restart from DONE repeats the identical run.
    run(mk("a_run2", 21, 2, 1, 1, 1, 32'h40400000, 32'h40000000), 1'b0, 1'b0);

    // Abort mid-run: reset while vector 1 is settling.
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (a_vec_rd && a_vec_addr == 2'd1) break;
      @(negedge clk);
    end
    chk("abort_fetch_v1", 64'(a_vec_rd && a_vec_addr == 2'd1), 64'd1);
    repeat (2) @(negedge clk);
    chk("abort_pre_pass", 64'(a_pass), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 64'(a_busy), 64'd0);
    chk("abort_done", 64'(a_done), 64'd0);
    chk("abort_pass", 64'(a_pass), 64'd0);
    chk("abort_fail", 64'(a_fail), 64'd0);
    chk("abort_ops", {a_a, a_b}, 64'd0);
    run(mk("a_run3", 21, 2, 1, 1, 1, 32'h40400000, 32'h40000000), 1'b0, 1'b0);

    // fail (0 vs 1.0), fail (bit 11 differs), pass (bits 10:0 differ only)
    rom_a[0] = {32'h3F800000, 32'hBF800000, 32'h3F800000};
    rom_a[1] = {32'h40400000, 32'h3F800000, 32'h40800800};
    rom_a[2] = {32'h40000000, 32'h3F800000, 32'h404007FF};
    run(mk("a_run4", 21, 1, 2, 1, 0, 32'h3F800000, 32'h00000000), 1'b0, 1'b0);

    // 1-bit counters: two passes and one fail saturate pass at 1.
    run(mk("b_run1", 12, 1, 1, 1, 2, 32'h00000800, 32'h00000000), 1'b1, 1'b0);
    rom_b[0] = {32'h3F800000, 32'h3F800000, 32'h40000001};
    rom_b[1] = {32'h3F800000, 32'h3F800000, 32'h40400000};
    rom_b[2] = {32'h40400000, 32'h3F800000, 32'h40000000};
    run(mk("b_run2", 12, 1, 1, 1, 1, 32'h40400000, 32'h40000000), 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fp_addsub_bist
`default_nettype wire
